// File: rtl/rv32i_sequencer_if.sv
// rv32i_sequencer_if: decode inputs and datapath control bundle of the RV32I sequencer.
// master = fetch/datapath side, slave = sequencer.
interface rv32i_sequencer_if #(
  parameter int unsigned N = 32
);
  logic [6:0]   op_code;
  logic [2:0]   func3;
  logic [6:0]   func7;
  logic [N-1:0] rs1_data;
  logic [4:0]   shamt;

  logic         shift_done;
  logic         wr_reg;
  logic         wr_mem;
  logic         alu_src;
  logic         store_sel;
  logic         jump;
  logic         jalr_ctl;
  logic [2:0]   branch;
  logic [2:0]   mux_sel_reg_file;
  logic [3:0]   alu_opcode;
  logic [N-1:0] shift_result;

  modport master (
    output op_code, func3, func7, rs1_data, shamt,
    input  shift_done, wr_reg, wr_mem, alu_src, store_sel, jump, jalr_ctl,
           branch, mux_sel_reg_file, alu_opcode, shift_result
  );

  modport slave (
    input  op_code, func3, func7, rs1_data, shamt,
    output shift_done, wr_reg, wr_mem, alu_src, store_sel, jump, jalr_ctl,
           branch, mux_sel_reg_file, alu_opcode, shift_result
  );
endinterface

// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer: RV32I control decode plus PC-advance gating.
// SERIAL_SHIFT_EN defined   : SLL/SRL/SRA(I) run on a bit-serial shifter (EXEC -> SHIFT x shamt -> WB).
// SERIAL_SHIFT_EN undefined : shifts retire in one cycle through the ALU; shift_result is tied to 0.
module rv32i_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst,
  rv32i_sequencer_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_UNC  = 3'b101;

  localparam logic [2:0] MUX_ALU   = 3'd0;
  localparam logic [2:0] MUX_LW    = 3'd1;
  localparam logic [2:0] MUX_LBU   = 3'd2;
  localparam logic [2:0] MUX_SHIFT = 3'd4;
  localparam logic [2:0] MUX_PC4   = 3'd5;
  localparam logic [2:0] MUX_IMM   = 3'd6;
  localparam logic [2:0] MUX_AUIPC = 3'd7;

  // ALU operation for R/I-type func3; alt selects SUB (R-type only) or SRA.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic       dec_wr_reg, dec_wr_mem, dec_alu_src, dec_store_sel, dec_jump, dec_jalr;
  logic [2:0] dec_branch, dec_mux;
  logic [3:0] dec_alu;
  logic       dec_is_shift;

  // Single-cycle decode of the current instruction fields.
  always_comb begin
    dec_wr_reg    = 1'b0;
    dec_wr_mem    = 1'b0;
    dec_alu_src   = 1'b0;
    dec_store_sel = 1'b0;
    dec_jump      = 1'b0;
    dec_jalr      = 1'b0;
    dec_branch    = BR_NONE;
    dec_mux       = MUX_ALU;
    dec_alu       = ALU_ADD;
    dec_is_shift  = 1'b0;
    case (bus.op_code)
      OP_R: begin
        dec_alu_src  = 1'b1;
        dec_wr_reg   = 1'b1;
        dec_alu      = alu_of(bus.func3, bus.func7[5]);
        dec_is_shift = (bus.func3[1:0] == 2'b01);
      end
      OP_I: begin
        dec_wr_reg   = 1'b1;
        // immediate bits overlap func7, so func7[5] only matters for SRAI
        dec_alu      = alu_of(bus.func3, (bus.func3 == 3'b101) && bus.func7[5]);
        dec_is_shift = (bus.func3[1:0] == 2'b01);
      end
      OP_LOAD: begin
        dec_wr_reg = 1'b1;
        dec_mux    = (bus.func3 == 3'b100) ? MUX_LBU : MUX_LW;
      end
      OP_STORE: begin
        dec_wr_mem    = 1'b1;
        dec_store_sel = (bus.func3 == 3'b000);
      end
      OP_BRANCH: begin
        dec_alu_src = 1'b1;
        dec_alu     = ALU_SUB;
        case (bus.func3)
          3'b000:  dec_branch = BR_BEQ;
          3'b001:  dec_branch = BR_BNE;
          3'b100:  dec_branch = BR_BLT;
          3'b101:  dec_branch = BR_BGE;
          default: dec_branch = BR_NONE;
        endcase
      end
      OP_JAL: begin
        dec_wr_reg = 1'b1;
        dec_branch = BR_UNC;
        dec_mux    = MUX_PC4;
      end
      OP_JALR: begin
        dec_wr_reg = 1'b1;
        dec_branch = BR_UNC;
        dec_mux    = MUX_PC4;
        dec_jump   = 1'b1;
        dec_jalr   = 1'b1;
      end
      OP_LUI: begin
        dec_wr_reg = 1'b1;
        dec_mux    = MUX_IMM;
      end
      OP_AUIPC: begin
        dec_wr_reg = 1'b1;
        dec_mux    = MUX_AUIPC;
      end
      default: ;
    endcase
  end

  logic unused_func7;
  assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

`ifdef SERIAL_SHIFT_EN
  typedef enum logic [1:0] {EXEC, SHIFT, WB} state_e;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [N-1:0] shres_q, shres_d;
  logic         right_q, right_d;
  logic         arith_q, arith_d;

  logic       o_shift_done, o_wr_reg, o_wr_mem, o_alu_src, o_store_sel, o_jump, o_jalr;
  logic [2:0] o_branch, o_mux;
  logic [3:0] o_alu;

  // Next-state, shifter datapath and state-dependent control overrides.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shres_d      = shres_q;
    right_d      = right_q;
    arith_d      = arith_q;
    o_shift_done = 1'b1;
    o_wr_reg     = dec_wr_reg;
    o_wr_mem     = dec_wr_mem;
    o_alu_src    = dec_alu_src;
    o_store_sel  = dec_store_sel;
    o_jump       = dec_jump;
    o_jalr       = dec_jalr;
    o_branch     = dec_branch;
    o_mux        = dec_mux;
    o_alu        = dec_alu;
    unique case (state_q)
      EXEC: begin
        if (dec_is_shift) begin
          shres_d      = bus.rs1_data;
          cnt_d        = bus.shamt;
          right_d      = bus.func3[2];
          arith_d      = bus.func3[2] & bus.func7[5];
          o_shift_done = 1'b0;
          o_wr_reg     = 1'b0;
          o_mux        = MUX_SHIFT;
          state_d      = (bus.shamt != 5'd0) ? SHIFT : WB;
        end
      end
      SHIFT: begin
        o_shift_done = 1'b0;
        o_wr_reg     = 1'b0;
        o_wr_mem     = 1'b0;
        o_alu_src    = 1'b0;
        o_store_sel  = 1'b0;
        o_jump       = 1'b0;
        o_jalr       = 1'b0;
        o_branch     = BR_NONE;
        o_mux        = MUX_SHIFT;
        o_alu        = ALU_ADD;
        shres_d      = right_q ? {arith_q & shres_q[N-1], shres_q[N-1:1]}
                               : {shres_q[N-2:0], 1'b0};
        cnt_d        = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) state_d = WB;
      end
      WB: begin
        o_shift_done = 1'b1;
        o_wr_reg     = 1'b1;
        o_wr_mem     = 1'b0;
        o_alu_src    = 1'b0;
        o_store_sel  = 1'b0;
        o_jump       = 1'b0;
        o_jalr       = 1'b0;
        o_branch     = BR_NONE;
        o_mux        = MUX_SHIFT;
        o_alu        = ALU_ADD;
        state_d      = EXEC;
      end
      default: state_d = EXEC;
    endcase
  end

  // Sequencer state, shift counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXEC;
      cnt_q   <= '0;
      shres_q <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shres_q <= shres_d;
      right_q <= right_d;
      arith_q <= arith_d;
    end
  end

  assign bus.shift_done       = o_shift_done;
  assign bus.wr_reg           = o_wr_reg;
  assign bus.wr_mem           = o_wr_mem;
  assign bus.alu_src          = o_alu_src;
  assign bus.store_sel        = o_store_sel;
  assign bus.jump             = o_jump;
  assign bus.jalr_ctl         = o_jalr;
  assign bus.branch           = o_branch;
  assign bus.mux_sel_reg_file = o_mux;
  assign bus.alu_opcode       = o_alu;
  assign bus.shift_result     = shres_q;
`else
  // Without the serial shifter the FSM never leaves EXEC, so it is not built.
  logic unused_serial;
  assign unused_serial = ^{clk, rst, bus.rs1_data, bus.shamt, dec_is_shift};

  assign bus.shift_done       = 1'b1;
  assign bus.wr_reg           = dec_wr_reg;
  assign bus.wr_mem           = dec_wr_mem;
  assign bus.alu_src          = dec_alu_src;
  assign bus.store_sel        = dec_store_sel;
  assign bus.jump             = dec_jump;
  assign bus.jalr_ctl         = dec_jalr;
  assign bus.branch           = dec_branch;
  assign bus.mux_sel_reg_file = dec_mux;
  assign bus.alu_opcode       = dec_alu;
  assign bus.shift_result     = '0;
`endif

endmodule

// File: tb/tb_rv32i_sequencer.sv
// tb_rv32i_sequencer: scoreboard bench for rv32i_sequencer (both SERIAL_SHIFT_EN builds).
module tb_rv32i_sequencer;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // fields fixed in WB: everything except alu_src and alu_opcode
  localparam logic [16:0] WB_MASK = 17'h1DFF0;

  logic clk;
  logic rst;

  rv32i_sequencer_if #(.N(32)) bus_if ();

  rv32i_sequencer #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] ctl;
    logic [31:0] res;
    int unsigned lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [4:0]  sh;
    logic [16:0] ctl;
    logic [31:0] res;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // {shift_done, wr_reg, wr_mem, alu_src, store_sel, jump, jalr_ctl, branch, mux, alu}
  function automatic logic [16:0] c(input int sd, input int wr, input int wm, input int as,
                                    input int ss, input int j, input int jr, input int br,
                                    input int mx, input int alu);
    return {1'(sd), 1'(wr), 1'(wm), 1'(as), 1'(ss), 1'(j), 1'(jr), 3'(br), 3'(mx), 4'(alu)};
  endfunction

  function automatic logic [16:0] obs();
    return {bus_if.shift_done, bus_if.wr_reg, bus_if.wr_mem, bus_if.alu_src, bus_if.store_sel,
            bus_if.jump, bus_if.jalr_ctl, bus_if.branch, bus_if.mux_sel_reg_file,
            bus_if.alu_opcode};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [4:0] sh);
    bus_if.op_code  = op;
    bus_if.func3    = f3;
    bus_if.func7    = f7;
    bus_if.rs1_data = rs1;
    bus_if.shamt    = sh;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    drive(OP_R, 3'b000, 7'h00, 32'h1234_5678, 5'd3);
    sb.push_back('{"reset_add", c(1,1,0,1,0,0,0,0,0,0), 32'h0, 1});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e.ctl) begin
      n_err++;
      $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
    end
    n_vec++;
    if (bus_if.shift_result !== e.res) begin
      n_err++;
      $display("FAIL %s shift_result: got %h expected %h", e.name, bus_if.shift_result, e.res);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_decode();
    vec_t tab[$];
    exp_t e;
    tab.push_back('{"add",    OP_R,      3'b000, 7'h00, 0, 0, c(1,1,0,1,0,0,0,0,0,0), 0});
    tab.push_back('{"sub",    OP_R,      3'b000, 7'h20, 0, 0, c(1,1,0,1,0,0,0,0,0,1), 0});
    tab.push_back('{"and",    OP_R,      3'b111, 7'h00, 0, 0, c(1,1,0,1,0,0,0,0,0,2), 0});
    tab.push_back('{"or",     OP_R,      3'b110, 7'h00, 0, 0, c(1,1,0,1,0,0,0,0,0,3), 0});
    tab.push_back('{"sltu",   OP_R,      3'b011, 7'h00, 0, 0, c(1,1,0,1,0,0,0,0,0,6), 0});
    tab.push_back('{"addi",   OP_I,      3'b000, 7'h20, 0, 0, c(1,1,0,0,0,0,0,0,0,0), 0});
    tab.push_back('{"xori",   OP_I,      3'b100, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,0,4), 0});
    tab.push_back('{"slti",   OP_I,      3'b010, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,0,5), 0});
    tab.push_back('{"lw",     OP_LOAD,   3'b010, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,1,0), 0});
    tab.push_back('{"lbu",    OP_LOAD,   3'b100, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,2,0), 0});
    tab.push_back('{"sw",     OP_STORE,  3'b010, 7'h00, 0, 0, c(1,0,1,0,0,0,0,0,0,0), 0});
    tab.push_back('{"sb",     OP_STORE,  3'b000, 7'h00, 0, 0, c(1,0,1,0,1,0,0,0,0,0), 0});
    tab.push_back('{"beq",    OP_BRANCH, 3'b000, 7'h00, 0, 0, c(1,0,0,1,0,0,0,1,0,1), 0});
    tab.push_back('{"bne",    OP_BRANCH, 3'b001, 7'h00, 0, 0, c(1,0,0,1,0,0,0,2,0,1), 0});
    tab.push_back('{"blt",    OP_BRANCH, 3'b100, 7'h00, 0, 0, c(1,0,0,1,0,0,0,3,0,1), 0});
    tab.push_back('{"bge",    OP_BRANCH, 3'b101, 7'h00, 0, 0, c(1,0,0,1,0,0,0,4,0,1), 0});
    tab.push_back('{"jal",    OP_JAL,    3'b000, 7'h00, 0, 0, c(1,1,0,0,0,0,0,5,5,0), 0});
    tab.push_back('{"jalr",   OP_JALR,   3'b000, 7'h00, 0, 0, c(1,1,0,0,0,1,1,5,5,0), 0});
    tab.push_back('{"lui",    OP_LUI,    3'b000, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,6,0), 0});
    tab.push_back('{"auipc",  OP_AUIPC,  3'b000, 7'h00, 0, 0, c(1,1,0,0,0,0,0,0,7,0), 0});
    tab.push_back('{"bad_op", 7'h7F,     3'b000, 7'h00, 0, 0, c(1,0,0,0,0,0,0,0,0,0), 0});
    foreach (tab[i]) begin
      @(posedge clk);
      #1 drive(tab[i].op, tab[i].f3, tab[i].f7, $urandom, 5'($urandom));
      sb.push_back('{tab[i].name, tab[i].ctl, 32'h0, 1});
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
      end
    end
  endtask

  task automatic test_shift();
    vec_t        tab[$];
    exp_t        e;
    int unsigned lat;
`ifdef SERIAL_SHIFT_EN
    tab.push_back('{"srai4",  OP_I, 3'b101, 7'h20, 32'h8000_0000, 5'd4,  0, 32'hF800_0000});
    tab.push_back('{"sll31",  OP_R, 3'b001, 7'h00, 32'h0000_0001, 5'd31, 0, 32'h8000_0000});
    tab.push_back('{"sll0",   OP_R, 3'b001, 7'h00, 32'h0000_0001, 5'd0,  0, 32'h0000_0001});
    tab.push_back('{"srl8",   OP_R, 3'b101, 7'h00, 32'hF000_0000, 5'd8,  0, 32'h00F0_0000});
    tab.push_back('{"sra_pos",OP_R, 3'b101, 7'h20, 32'h4000_0000, 5'd3,  0, 32'h0800_0000});
    tab.push_back('{"slli5",  OP_I, 3'b001, 7'h00, 32'h0000_00FF, 5'd5,  0, 32'h0000_1FE0});
    foreach (tab[i]) begin
      @(posedge clk);
      #1 drive(tab[i].op, tab[i].f3, tab[i].f7, tab[i].rs1, tab[i].sh);
      sb.push_back('{tab[i].name, c(1,1,0,0,0,0,0,0,4,0), tab[i].res, 32'(tab[i].sh) + 2});
      @(negedge clk);
      lat = 1;
      n_vec++;
      if ({bus_if.shift_done, bus_if.wr_reg} !== 2'b00) begin
        n_err++;
        $display("FAIL %s exec {shift_done,wr_reg}: got %b expected 00", tab[i].name,
                 {bus_if.shift_done, bus_if.wr_reg});
      end
      while (bus_if.shift_done !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
        if (bus_if.shift_done !== 1'b1) begin
          n_vec++;
          if ({bus_if.wr_reg, bus_if.wr_mem} !== 2'b00) begin
            n_err++;
            $display("FAIL %s stall {wr_reg,wr_mem} cycle %0d: got %b expected 00", tab[i].name,
                     lat, {bus_if.wr_reg, bus_if.wr_mem});
          end
        end
      end
      e = sb.pop_front();
      n_vec++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d expected %0d", e.name, lat, e.lat);
      end
      n_vec++;
      if ((obs() & WB_MASK) !== (e.ctl & WB_MASK)) begin
        n_err++;
        $display("FAIL %s wb ctl: got %h expected %h", e.name, obs() & WB_MASK, e.ctl & WB_MASK);
      end
      n_vec++;
      if (bus_if.shift_result !== e.res) begin
        n_err++;
        $display("FAIL %s shift_result: got %h expected %h", e.name, bus_if.shift_result, e.res);
      end
    end
`else
    lat = 1;
    tab.push_back('{"srl_alu",  OP_R, 3'b101, 7'h00, 32'hF000_0000, 5'd8, c(1,1,0,1,0,0,0,0,0,8), 0});
    tab.push_back('{"sra_alu",  OP_R, 3'b101, 7'h20, 32'h8000_0000, 5'd4, c(1,1,0,1,0,0,0,0,0,9), 0});
    tab.push_back('{"sll_alu",  OP_R, 3'b001, 7'h00, 32'h0000_0001, 5'd31,c(1,1,0,1,0,0,0,0,0,7), 0});
    tab.push_back('{"slli_alu", OP_I, 3'b001, 7'h00, 32'h0000_00FF, 5'd0, c(1,1,0,0,0,0,0,0,0,7), 0});
    tab.push_back('{"srai_alu", OP_I, 3'b101, 7'h20, 32'h8000_0000, 5'd4, c(1,1,0,0,0,0,0,0,0,9), 0});
    tab.push_back('{"srli_alu", OP_I, 3'b101, 7'h00, 32'hFFFF_FFFF, 5'd1, c(1,1,0,0,0,0,0,0,0,8), 0});
    foreach (tab[i]) begin
      @(posedge clk);
      #1 drive(tab[i].op, tab[i].f3, tab[i].f7, tab[i].rs1, tab[i].sh);
      sb.push_back('{tab[i].name, tab[i].ctl, tab[i].res, lat});
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (obs() !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
      end
      n_vec++;
      if (bus_if.shift_result !== e.res) begin
        n_err++;
        $display("FAIL %s shift_result: got %h expected %h", e.name, bus_if.shift_result, e.res);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk);
`ifdef SERIAL_SHIFT_EN
    #1 drive(OP_I, 3'b101, 7'h00, 32'hA5A5_0000, 5'd0);
    sb.push_back('{"b2b_srli0", c(1,1,0,0,0,0,0,0,4,0), 32'hA5A5_0000, 2});
    @(negedge clk);
    n_vec++;
    if (bus_if.shift_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_srli0 exec shift_done: got %b expected 0", bus_if.shift_done);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if ((obs() & WB_MASK) !== (e.ctl & WB_MASK)) begin
      n_err++;
      $display("FAIL %s wb ctl: got %h expected %h", e.name, obs() & WB_MASK, e.ctl & WB_MASK);
    end
    n_vec++;
    if (bus_if.shift_result !== e.res) begin
      n_err++;
      $display("FAIL %s shift_result: got %h expected %h", e.name, bus_if.shift_result, e.res);
    end
`else
    #1 drive(OP_I, 3'b101, 7'h20, 32'hA5A5_0000, 5'd3);
    sb.push_back('{"b2b_srai", c(1,1,0,0,0,0,0,0,0,9), 32'h0, 1});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e.ctl) begin
      n_err++;
      $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
    end
`endif
    @(posedge clk);
    #1 drive(OP_R, 3'b000, 7'h00, 32'h0, 5'd0);
    sb.push_back('{"b2b_add", c(1,1,0,1,0,0,0,0,0,0), 32'h0, 1});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e.ctl) begin
      n_err++;
      $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
    end
  endtask

  task automatic test_rst_abort();
    exp_t e;
    @(posedge clk);
`ifdef SERIAL_SHIFT_EN
    // SLLI by 10: after 8 clock edges the shifter is in SHIFT with counter 3
    #1 drive(OP_I, 3'b001, 7'h00, 32'h0000_0001, 5'd10);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus_if.shift_done, bus_if.wr_reg} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_abort shift cycle {shift_done,wr_reg}: got %b expected 00",
               {bus_if.shift_done, bus_if.wr_reg});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive(OP_R, 3'b000, 7'h00, 32'h0, 5'd0);
    sb.push_back('{"rst_abort_add", c(1,1,0,1,0,0,0,0,0,0), 32'h0, 1});
`else
    #1 rst = 1'b1;
    drive(OP_I, 3'b001, 7'h00, 32'hDEAD_BEEF, 5'd3);
    sb.push_back('{"rst_slli", c(1,1,0,0,0,0,0,0,0,7), 32'h0, 1});
`endif
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (obs() !== e.ctl) begin
      n_err++;
      $display("FAIL %s ctl: got %h expected %h", e.name, obs(), e.ctl);
    end
    n_vec++;
    if (bus_if.shift_result !== e.res) begin
      n_err++;
      $display("FAIL %s shift_result: got %h expected %h", e.name, bus_if.shift_result, e.res);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_shift();
    test_back_to_back();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
